tpu_sequencer: RTL and testbench
================================

Name: tpu_sequencer

Overview:
- Command-level controller that sequences the TPU core's phases (reset, weight FIFO fill, FIFO drain into array, multiply) on behalf of the Avalon slave wrapper.
- Replaces free-running control flops with a handshaked FSM. Waits on the TPU done flags, enforces a per-phase timeout and exposes status for host polling.
- Sits between the memory-mapped control register decode and the TPU top-level control and base-address inputs.

Parameters:
- ADDR_WIDTH, 8, width of the input, output and weight memory base addresses.
- RESET_CYCLES, 4, number of cycles tpu_reset is held during a RESET op (minimum 1).
- TIMEOUT_CYCLES, 1024, maximum cycles spent in any wait phase before abort.
- CNT_WIDTH, 16, width of the phase and performance counters (must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  opcode: F=RESET, 1=FILL, 2=DRAIN, 3=MULTIPLY, 4=RUN_ALL
- cmd_in_base  in  ADDR_WIDTH  input memory read base
- cmd_out_base  in  ADDR_WIDTH  output memory write base
- cmd_wt_base  in  ADDR_WIDTH  weight memory read base
- tpu_reset  out  1  active-high reset to the TPU core
- tpu_fill_fifo  out  1  fill weight FIFO enable
- tpu_drain_fifo  out  1  drain FIFO into array enable
- tpu_active  out  1  multiply enable
- input_rd_addr_base  out  ADDR_WIDTH  latched cmd_in_base
- output_wr_addr_base  out  ADDR_WIDTH  latched cmd_out_base
- weight_rd_addr_base  out  ADDR_WIDTH  latched cmd_wt_base
- mem_to_fifo_done  in  1  TPU fill complete
- fifo_to_arr_done  in  1  TPU drain complete
- output_done  in  1  TPU multiply complete
- done_clear  in  1  clears status_done and status_error
- status_busy  out  1  FSM not in IDLE
- status_done  out  1  sticky flag: last command completed successfully
- status_error  out  1  sticky flag: timeout or illegal opcode
- status_op  out  4  opcode of the current or last command

Behaviour:
- Reset (reset==0 at a clk edge): FSM goes to IDLE.
  - All outputs become 0, except cmd_ready, which becomes 1.
  - Base outputs become 0; status_op becomes 0.
  - Counters clear.
  - Reset overrides any in-flight phase within one edge.
- FSM states: IDLE, RST, FILL, DRAIN, MULT.
- Command acceptance: a command is accepted at an edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready = (state==IDLE).
  - On acceptance, the three bases and status_op latch, and status_done and status_error clear.
- Dispatch on accept:
  - F goes to RST.
  - 1 goes to FILL.
  - 2 goes to DRAIN.
  - 3 goes to MULT.
  - 4 goes to FILL with the chain flag set.
  - Any other opcode: stay in IDLE and set status_error=1. No strobe asserts.
- Strobes are Moore outputs, high exactly while in the matching state:
  - tpu_reset in RST.
  - tpu_fill_fifo in FILL.
  - tpu_drain_fifo in DRAIN.
  - tpu_active in MULT.
  - The first strobe cycle is the cycle after the accepting edge.
- RST: held exactly RESET_CYCLES cycles, then IDLE. Sets status_done unless entered via abort.
- Wait phases (FILL, DRAIN, MULT): the phase counter starts at 0 on entry.
  - The matching done input is ignored on the entry cycle, to reject stale flags.
  - From cycle 1 onward, done==1 at an edge completes the phase.
- Completion transitions:
  - FILL goes to DRAIN if chained, else IDLE.
  - DRAIN goes to MULT if chained, else IDLE.
  - MULT goes to IDLE.
  - Entering IDLE on completion sets status_done=1 and clears the chain flag.
  - Chained phase transitions have zero bubble: the next strobe rises on the same edge the previous one falls.
- Timeout: if the phase counter reaches TIMEOUT_CYCLES-1 without done, the next edge aborts.
  - Strobe drops, status_error=1, chain flag clears.
  - FSM goes to RST, which auto-resets the TPU, then to IDLE. status_done stays 0.
- done_clear: in IDLE, clears both sticky flags.
  - If it coincides with an edge that sets a flag, the set wins.
  - done_clear is ignored while busy.
- Base outputs hold their latched values until the next accepted command.
- status_busy = (state!=IDLE).

Optional Feature:
- Macro: TPU_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles [CNT_WIDTH-1:0], which counts every cycle from acceptance until return to IDLE, saturating at all-ones.
  - The value holds in IDLE and clears on the next acceptance or on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset released, then RESET op (F) with RESET_CYCLES=4 -> tpu_reset high exactly 4 cycles; status_done=1; cmd_ready returns 1.
- FILL op with wt_base=0x20; mem_to_fifo_done pulsed 10 cycles after accept -> tpu_fill_fifo high 10 cycles; weight_rd_addr_base=0x20; status_done=1.
- RUN_ALL op with each done driven on cycle 5 of its phase -> fill, drain and active strobes are contiguous and non-overlapping (15 cycles total); single status_done at end.
- MULTIPLY op with output_done held low and TIMEOUT_CYCLES=16 -> tpu_active drops after 16 cycles; tpu_reset pulses 4 cycles; status_error=1, status_done=0.
- Opcode 7 -> no strobe asserts; status_error=1; then done_clear -> status_error=0.
- Reset asserted mid-DRAIN, with done already high on the DRAIN entry cycle -> all strobes 0 on the next edge; stale done is not acted on after re-issue.

Source files
------------

// File: rtl/tpu_sequencer.sv
// Command sequencer for the TPU core: handshaked RESET/FILL/DRAIN/MULTIPLY/RUN_ALL phases
// with per-phase timeout and sticky status. Optional TPU_SEQ_PERF_EN adds a busy-cycle counter.
module tpu_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_in_base,
  input  logic [ADDR_WIDTH-1:0] cmd_out_base,
  input  logic [ADDR_WIDTH-1:0] cmd_wt_base,
  output logic                  tpu_reset,
  output logic                  tpu_fill_fifo,
  output logic                  tpu_drain_fifo,
  output logic                  tpu_active,
  output logic [ADDR_WIDTH-1:0] input_rd_addr_base,
  output logic [ADDR_WIDTH-1:0] output_wr_addr_base,
  output logic [ADDR_WIDTH-1:0] weight_rd_addr_base,
  input  logic                  mem_to_fifo_done,
  input  logic                  fifo_to_arr_done,
  input  logic                  output_done,
  input  logic                  done_clear,
  output logic                  status_busy,
  output logic                  status_done,
  output logic                  status_error,
  output logic [3:0]            status_op
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  perf_cycles
`endif
);

  localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_FILL, S_DRAIN, S_MULT} state_t;

  state_t               state;
  logic [5:0]           ctl_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 chain;
  logic                 abort;
  logic                 phase_done_c;

  // Registered output image of a state: {busy, ready, reset, fill, drain, active}
  function automatic logic [5:0] decode(input state_t s);
    decode = {s != S_IDLE, s == S_IDLE, s == S_RST, s == S_FILL, s == S_DRAIN, s == S_MULT};
  endfunction

  assign {status_busy, cmd_ready, tpu_reset, tpu_fill_fifo, tpu_drain_fifo, tpu_active} = ctl_q;

  assign phase_done_c = (state == S_FILL  && mem_to_fifo_done) ||
                        (state == S_DRAIN && fifo_to_arr_done) ||
                        (state == S_MULT  && output_done);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= S_IDLE;
      ctl_q               <= decode(S_IDLE);
      cnt                 <= '0;
      chain               <= 1'b0;
      abort               <= 1'b0;
      input_rd_addr_base  <= '0;
      output_wr_addr_base <= '0;
      weight_rd_addr_base <= '0;
      status_done         <= 1'b0;
      status_error        <= 1'b0;
      status_op           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (done_clear) begin
            status_done  <= 1'b0;
            status_error <= 1'b0;
          end
          if (cmd_valid && cmd_ready) begin
            input_rd_addr_base  <= cmd_in_base;
            output_wr_addr_base <= cmd_out_base;
            weight_rd_addr_base <= cmd_wt_base;
            status_op           <= cmd_op;
            status_done         <= 1'b0;
            status_error        <= 1'b0;
            cnt                 <= '0;
            abort               <= 1'b0;
            chain               <= (cmd_op == 4'h4);
            case (cmd_op)
              4'hF: begin state <= S_RST;   ctl_q <= decode(S_RST);   end
              4'h1: begin state <= S_FILL;  ctl_q <= decode(S_FILL);  end
              4'h2: begin state <= S_DRAIN; ctl_q <= decode(S_DRAIN); end
              4'h3: begin state <= S_MULT;  ctl_q <= decode(S_MULT);  end
              4'h4: begin state <= S_FILL;  ctl_q <= decode(S_FILL);  end
              default: status_error <= 1'b1;
            endcase
          end
        end
        S_RST: begin
          if (cnt == RST_LAST) begin
            state <= S_IDLE;
            ctl_q <= decode(S_IDLE);
            cnt   <= '0;
            abort <= 1'b0;
            if (!abort) status_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        S_FILL, S_DRAIN, S_MULT: begin
          // Done is ignored on the entry cycle (cnt==0) so a stale flag cannot complete a phase
          if (cnt != '0 && phase_done_c) begin
            cnt <= '0;
            if (state == S_FILL && chain) begin
              state <= S_DRAIN;
              ctl_q <= decode(S_DRAIN);
            end else if (state == S_DRAIN && chain) begin
              state <= S_MULT;
              ctl_q <= decode(S_MULT);
            end else begin
              state       <= S_IDLE;
              ctl_q       <= decode(S_IDLE);
              chain       <= 1'b0;
              status_done <= 1'b1;
            end
          end else if (cnt == TO_LAST) begin
            state        <= S_RST;
            ctl_q        <= decode(S_RST);
            cnt          <= '0;
            chain        <= 1'b0;
            abort        <= 1'b1;
            status_error <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          ctl_q <= decode(S_IDLE);
        end
      endcase
    end
  end

`ifdef TPU_SEQ_PERF_EN
  // Busy-cycle counter: cleared on acceptance, saturates, holds in IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE) begin
      if (cmd_valid && cmd_ready) perf_cycles <= '0;
    end else if (perf_cycles != '1) begin
      perf_cycles <= perf_cycles + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: command vector table with a completion scoreboard,
// plus hand-written reset, done_clear and stale-done sequences.
module tb_tpu_sequencer;
  localparam int unsigned AW = 8;
  localparam int unsigned RC = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_in_base, cmd_out_base, cmd_wt_base;
  logic          tpu_reset, tpu_fill_fifo, tpu_drain_fifo, tpu_active;
  logic [AW-1:0] input_rd_addr_base, output_wr_addr_base, weight_rd_addr_base;
  logic          mem_to_fifo_done, fifo_to_arr_done, output_done, done_clear;
  logic          status_busy, status_done, status_error;
  logic [3:0]    status_op;
`ifdef TPU_SEQ_PERF_EN
  logic [CW-1:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  tpu_sequencer #(
    .ADDR_WIDTH(AW), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_in_base(cmd_in_base), .cmd_out_base(cmd_out_base), .cmd_wt_base(cmd_wt_base),
    .tpu_reset(tpu_reset), .tpu_fill_fifo(tpu_fill_fifo),
    .tpu_drain_fifo(tpu_drain_fifo), .tpu_active(tpu_active),
    .input_rd_addr_base(input_rd_addr_base), .output_wr_addr_base(output_wr_addr_base),
    .weight_rd_addr_base(weight_rd_addr_base),
    .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done),
    .output_done(output_done), .done_clear(done_clear),
    .status_busy(status_busy), .status_done(status_done),
    .status_error(status_error), .status_op(status_op)
`ifdef TPU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // done_at: phase cycle index (0 = entry cycle) on which the phase's done is driven; -1 = never
  typedef struct {
    logic [3:0] op;
    logic [7:0] in_b, out_b, wt_b;
    int         done_at;
    int         n_rst, n_fill, n_drain, n_act;
    logic       ok, err;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t       e;
    int         c_rst, c_fill, c_drain, c_act, gaps, olap, run;
    logic [3:0] s, ps;
    bit         fin;
    cmd_valid    = 1'b1;
    cmd_op       = v.op;
    cmd_in_base  = v.in_b;
    cmd_out_base = v.out_b;
    cmd_wt_base  = v.wt_b;
    sb.push_back(v);
    tick();
    cmd_valid = 1'b0;
    c_rst = 0; c_fill = 0; c_drain = 0; c_act = 0; gaps = 0; olap = 0; run = 0;
    ps = '0; fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (cmd_ready) begin
        fin = 1'b1;
      end else begin
        s = {tpu_reset, tpu_fill_fifo, tpu_drain_fifo, tpu_active};
        c_rst   += int'(tpu_reset);
        c_fill  += int'(tpu_fill_fifo);
        c_drain += int'(tpu_drain_fifo);
        c_act   += int'(tpu_active);
        if ($countones(s) > 1) olap++;
        if (s == '0) gaps++;
        run = (s == ps) ? run + 1 : 0;
        ps  = s;
        mem_to_fifo_done = tpu_fill_fifo  && (run == v.done_at);
        fifo_to_arr_done = tpu_drain_fifo && (run == v.done_at);
        output_done      = tpu_active     && (run == v.done_at);
        tick();
      end
    end
    mem_to_fifo_done = 1'b0;
    fifo_to_arr_done = 1'b0;
    output_done      = 1'b0;
    e = sb.pop_front();
    check($sformatf("v%0d_complete", idx), 32'(fin), 32'd1);
    check($sformatf("v%0d_rst_cycles", idx), 32'(c_rst), 32'(e.n_rst));
    check($sformatf("v%0d_fill_cycles", idx), 32'(c_fill), 32'(e.n_fill));
    check($sformatf("v%0d_drain_cycles", idx), 32'(c_drain), 32'(e.n_drain));
    check($sformatf("v%0d_active_cycles", idx), 32'(c_act), 32'(e.n_act));
    check($sformatf("v%0d_overlap", idx), 32'(olap), 32'd0);
    check($sformatf("v%0d_bubble", idx), 32'(gaps), 32'd0);
    check($sformatf("v%0d_status_done", idx), 32'(status_done), 32'(e.ok));
    check($sformatf("v%0d_status_error", idx), 32'(status_error), 32'(e.err));
    check($sformatf("v%0d_status_op", idx), 32'(status_op), 32'(e.op));
    check($sformatf("v%0d_busy", idx), 32'(status_busy), 32'd0);
    check($sformatf("v%0d_in_base", idx), 32'(input_rd_addr_base), 32'(e.in_b));
    check($sformatf("v%0d_out_base", idx), 32'(output_wr_addr_base), 32'(e.out_b));
    check($sformatf("v%0d_wt_base", idx), 32'(weight_rd_addr_base), 32'(e.wt_b));
`ifdef TPU_SEQ_PERF_EN
    check($sformatf("v%0d_perf", idx), 32'(perf_cycles),
          32'(e.n_rst + e.n_fill + e.n_drain + e.n_act));
`endif
  endtask

  initial begin
    vecs[0] = '{4'hF, 8'h11, 8'h12, 8'h13, -1, 4, 0, 0, 0, 1'b1, 1'b0};
    vecs[1] = '{4'h1, 8'h01, 8'h02, 8'h20,  9, 0, 10, 0, 0, 1'b1, 1'b0};
    vecs[2] = '{4'h4, 8'h31, 8'h32, 8'h33,  4, 0, 5, 5, 5, 1'b1, 1'b0};
    vecs[3] = '{4'h3, 8'h41, 8'h42, 8'h43, -1, 4, 0, 0, 16, 1'b0, 1'b1};
    vecs[4] = '{4'h7, 8'h51, 8'h52, 8'h53, -1, 0, 0, 0, 0, 1'b0, 1'b1};
    vecs[5] = '{4'h2, 8'h61, 8'h62, 8'h63,  0, 4, 0, 16, 0, 1'b0, 1'b1};
    vecs[6] = '{4'h2, 8'h71, 8'h72, 8'h73,  1, 0, 0, 2, 0, 1'b1, 1'b0};
    vecs[7] = '{4'h1, 8'h81, 8'h82, 8'h83, 15, 0, 16, 0, 0, 1'b1, 1'b0};
    vecs[8] = '{4'h0, 8'h91, 8'h92, 8'h93, -1, 0, 0, 0, 0, 1'b0, 1'b1};

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_in_base = '0; cmd_out_base = '0; cmd_wt_base = '0;
    mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0; done_clear = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_strobes", 32'({tpu_reset, tpu_fill_fifo, tpu_drain_fifo, tpu_active}), 32'd0);
    check("rst_status", 32'({status_busy, status_done, status_error}), 32'd0);
    check("rst_op", 32'(status_op), 32'd0);
    check("rst_bases", 32'({input_rd_addr_base, output_wr_addr_base, weight_rd_addr_base}), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // done_clear in IDLE clears the sticky error left by the illegal opcode
    done_clear = 1'b1;
    tick();
    done_clear = 1'b0;
    check("clear_error", 32'(status_error), 32'd0);
    check("clear_done", 32'(status_done), 32'd0);

    // done_clear coinciding with an illegal-opcode accept: the set wins
    cmd_valid = 1'b1; cmd_op = 4'h9; done_clear = 1'b1;
    tick();
    cmd_valid = 1'b0; done_clear = 1'b0;
    check("clear_vs_set_error", 32'(status_error), 32'd1);
    check("illegal_no_strobe", 32'({tpu_reset, tpu_fill_fifo, tpu_drain_fifo, tpu_active}), 32'd0);

    // Reset in the middle of DRAIN with done already high
    cmd_valid = 1'b1; cmd_op = 4'h2; fifo_to_arr_done = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("mid_drain_on", 32'(tpu_drain_fifo), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_reset_strobes", 32'({tpu_reset, tpu_fill_fifo, tpu_drain_fifo, tpu_active}), 32'd0);
    check("mid_reset_ready", 32'({cmd_ready, status_busy}), 32'd2);
    reset = 1'b1;

    // Re-issue DRAIN; done high only through the entry cycle must be ignored
    cmd_valid = 1'b1; cmd_op = 4'h2;
    tick();
    cmd_valid = 1'b0;
    tick();
    fifo_to_arr_done = 1'b0;
    check("stale_done_ignored", 32'({tpu_drain_fifo, status_busy}), 32'd3);
    repeat (2) tick();
    check("stale_still_drain", 32'(tpu_drain_fifo), 32'd1);
    fifo_to_arr_done = 1'b1;
    tick();
    fifo_to_arr_done = 1'b0;
    check("reissue_complete", 32'({tpu_drain_fifo, cmd_ready, status_done}), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
